// File: rtl/acorn_pkg.sv
// Shared ACORN-128 definitions: state geometry, phase lengths, FSM encoding,
// feedback/keystream tap positions and the boolean helpers of StateUpdate128.
package acorn_pkg;

  localparam int unsigned ACORN_STATE_W = 293;
  localparam int unsigned PAD_BITS      = 256;
  localparam int unsigned CA_ONE_BITS   = 128;
  localparam int unsigned CNT_W         = 10;

  // FSM encoding kept as plain constants so legacy code can compare raw bits.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ENC  = ST_ENC,
    PAD  = ST_PAD,
    DONE = ST_DONE
  } acorn_fsm_e;

  localparam int unsigned TAP_0   = 0;
  localparam int unsigned TAP_12  = 12;
  localparam int unsigned TAP_23  = 23;
  localparam int unsigned TAP_61  = 61;
  localparam int unsigned TAP_66  = 66;
  localparam int unsigned TAP_107 = 107;
  localparam int unsigned TAP_111 = 111;
  localparam int unsigned TAP_154 = 154;
  localparam int unsigned TAP_160 = 160;
  localparam int unsigned TAP_193 = 193;
  localparam int unsigned TAP_196 = 196;
  localparam int unsigned TAP_230 = 230;
  localparam int unsigned TAP_235 = 235;
  localparam int unsigned TAP_244 = 244;
  localparam int unsigned TAP_289 = 289;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn_step.sv
// acorn_step: one combinational ACORN-128 StateUpdate128 step.
// Ports:
//   state      - current 293-bit state
//   m, ca, cb  - message bit and control bits for this step
//   next_state - state after feedback, new-bit computation and shift
//   ks         - keystream bit derived from the pre-shift (feedback-updated) state
module acorn_step
  import acorn_pkg::*;
(
  input  logic [ACORN_STATE_W-1:0] state,
  input  logic                     m,
  input  logic                     ca,
  input  logic                     cb,
  output logic [ACORN_STATE_W-1:0] next_state,
  output logic                     ks
);

  logic [ACORN_STATE_W-1:0] upd;
  logic                     f;

  // LFSR feedback, applied in order; later updates see earlier ones.
  always_comb begin
    upd          = state;
    upd[TAP_289] = upd[TAP_289] ^ upd[TAP_235] ^ upd[TAP_230];
    upd[TAP_230] = upd[TAP_230] ^ upd[TAP_196] ^ upd[TAP_193];
    upd[TAP_193] = upd[TAP_193] ^ upd[TAP_160] ^ upd[TAP_154];
    upd[TAP_154] = upd[TAP_154] ^ upd[TAP_111] ^ upd[TAP_107];
    upd[TAP_107] = upd[TAP_107] ^ upd[TAP_66]  ^ upd[TAP_61];
    upd[TAP_61]  = upd[TAP_61]  ^ upd[TAP_23]  ^ upd[TAP_0];
  end

  // Kept separate from the feedback block so ks never depends on m.
  assign ks = upd[TAP_12] ^ upd[TAP_154]
            ^ maj(upd[TAP_235], upd[TAP_61], upd[TAP_193])
            ^ ch(upd[TAP_230], upd[TAP_111], upd[TAP_66]);

  assign f = upd[TAP_0] ^ ~upd[TAP_107]
           ^ maj(upd[TAP_244], upd[TAP_23], upd[TAP_160])
           ^ (ca & upd[TAP_196]) ^ (cb & ks) ^ m;

  assign next_state = {f, upd[ACORN_STATE_W-1:1]};

endmodule

// File: rtl/plaintext_process.sv
// plaintext_process: ACORN-128 encryption stage. Loads the associated-data
// state and one plaintext block on start, runs PT_BITS encryption steps
// (one ciphertext bit per cycle, bit 0 first), then 256 padding steps,
// then pulses done with ct_out/state_out held until the next start.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - request, accepted only in IDLE
//   state_in   - incoming 293-bit state (sampled with start)
//   pt_in      - plaintext block (sampled with start)
//   dec        - DECRYPT_EN builds only: pt_in carries ciphertext
//   busy       - high while encrypting/padding
//   done       - one-cycle completion pulse
//   ct_out     - ciphertext (or recovered plaintext when decrypting)
//   state_out  - state after plaintext and padding
// Build option: define DECRYPT_EN to add the dec input and decrypt mode.
module plaintext_process
  import acorn_pkg::*;
#(
  parameter int unsigned PT_BITS = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ACORN_STATE_W-1:0] state_in,
  input  logic [PT_BITS-1:0]       pt_in,
`ifdef DECRYPT_EN
  input  logic                     dec,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [PT_BITS-1:0]       ct_out,
  output logic [ACORN_STATE_W-1:0] state_out
);

  localparam int unsigned STATE_W  = ACORN_STATE_W;
  localparam logic [CNT_W-1:0] ENC_LAST = CNT_W'(PT_BITS - 1);
  localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(PAD_BITS - 1);
  localparam logic [CNT_W-1:0] CA_LIM   = CNT_W'(CA_ONE_BITS);

  acorn_fsm_e         fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] st_q;
  logic [PT_BITS-1:0] pt_q;
  logic [PT_BITS-1:0] ct_q;
  logic               busy_q, done_q;
  logic               dec_sel;

  logic               step_m, step_ca;
  logic [STATE_W-1:0] step_next;
  logic               step_ks;
  logic               ct_bit;

`ifdef DECRYPT_EN
  logic dec_q;
  assign dec_sel = dec_q;
`else
  assign dec_sel = 1'b0;
`endif

  acorn_step u_step (
    .state      (st_q),
    .m          (step_m),
    .ca         (step_ca),
    .cb         (1'b0),
    .next_state (step_next),
    .ks         (step_ks)
  );

  // Ciphertext bit uses the keystream of the pre-update state this cycle.
  assign ct_bit = pt_q[0] ^ step_ks;

  // Step inputs; decrypt absorbs the recovered plaintext bit.
  always_comb begin
    step_m  = 1'b0;
    step_ca = 1'b0;
    case (fsm_q)
      ENC: begin
        step_m  = pt_q[0] ^ (dec_sel & step_ks);
        step_ca = 1'b1;
      end
      PAD: begin
        step_m  = (cnt_q == '0);
        step_ca = (cnt_q < CA_LIM);
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state and counter logic; exits on terminal count, no wrap.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = ENC;
          cnt_d = '0;
        end
      end
      ENC: begin
        if (cnt_q == ENC_LAST) begin
          fsm_d = PAD;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PAD: begin
        if (cnt_q == PAD_LAST) begin
          fsm_d = DONE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: fsm_d = IDLE;
      default: begin
        fsm_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      st_q   <= '0;
      pt_q   <= '0;
      ct_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DECRYPT_EN
      dec_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (fsm_d == ENC) || (fsm_d == PAD);
      done_q <= (fsm_d == DONE);
      case (fsm_q)
        IDLE: begin
          if (start) begin
            st_q  <= state_in;
            pt_q  <= pt_in;
`ifdef DECRYPT_EN
            dec_q <= dec;
`endif
          end
        end
        ENC: begin
          st_q <= step_next;
          pt_q <= pt_q >> 1;
          // Shift in from the top: after PT_BITS steps bit 0 holds ct[0].
          ct_q <= (ct_q >> 1) | (PT_BITS'(ct_bit) << (PT_BITS - 1));
        end
        PAD: st_q <= step_next;
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ct_out    = ct_q;
  assign state_out = st_q;

endmodule

// File: tb/tb_plaintext_process.sv
// Scoreboard bench for plaintext_process: expected ciphertext/state are
// queued at each accepted start and checked by a monitor on every done.
module tb_plaintext_process;

  localparam int unsigned PT  = 128;
  localparam int unsigned SW  = 293;
  localparam int unsigned LAT = PT + 257;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] state_in;
  logic [PT-1:0] pt_in;
`ifdef DECRYPT_EN
  logic          dec;
`endif
  logic          busy;
  logic          done;
  logic [PT-1:0] ct_out;
  logic [SW-1:0] state_out;

  plaintext_process #(.PT_BITS(PT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .state_in  (state_in),
    .pt_in     (pt_in),
`ifdef DECRYPT_EN
    .dec       (dec),
`endif
    .busy      (busy),
    .done      (done),
    .ct_out    (ct_out),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [PT-1:0] ct;
    logic [SW-1:0] st;
    logic          hand_en;
    logic          hand_ct0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   start_cyc = 0;

  function automatic void chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  // Reference StateUpdate128 with cb fixed at 0.
  function automatic void model_step(input logic [SW-1:0] si, input logic m, input logic ca,
                                     output logic [SW-1:0] so, output logic ks);
    logic [SW-1:0] t;
    logic          fb;
    t = si;
    t[289] = t[289] ^ t[235] ^ t[230];
    t[230] = t[230] ^ t[196] ^ t[193];
    t[193] = t[193] ^ t[160] ^ t[154];
    t[154] = t[154] ^ t[111] ^ t[107];
    t[107] = t[107] ^ t[66]  ^ t[61];
    t[61]  = t[61]  ^ t[23]  ^ t[0];
    ks = t[12] ^ t[154]
       ^ ((t[235] & t[61]) | (t[235] & t[193]) | (t[61] & t[193]))
       ^ (t[230] ? t[111] : t[66]);
    fb = t[0] ^ ~t[107]
       ^ ((t[244] & t[23]) | (t[244] & t[160]) | (t[23] & t[160]))
       ^ (ca & t[196]) ^ m;
    so = t >> 1;
    so[SW-1] = fb;
  endfunction

  function automatic void model_run(input logic [SW-1:0] s0, input logic [PT-1:0] p0,
                                    output logic [PT-1:0] ct, output logic [SW-1:0] sf);
    logic [SW-1:0] s;
    logic [PT-1:0] p;
    logic          ks;
    logic          b;
    s  = s0;
    p  = p0;
    ct = '0;
    for (int i = 0; i < int'(PT); i++) begin
      b = p[0];
      p = p >> 1;
      model_step(s, b, 1'b1, s, ks);
      ct = (ct >> 1) | {b ^ ks, {(PT-1){1'b0}}};
    end
    for (int j = 0; j < 256; j++) begin
      model_step(s, (j == 0), (j < 128), s, ks);
    end
    sf = s;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] v;
    v = '0;
    for (int k = 0; k < 10; k++) v = (v << 32) | SW'($urandom());
    return v;
  endfunction

  function automatic logic [PT-1:0] rand_pt();
    logic [PT-1:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v = (v << 32) | PT'($urandom());
    return v;
  endfunction

  task automatic push_exp(input logic [SW-1:0] s, input logic [PT-1:0] p,
                          input logic hen, input logic h0);
    exp_t e;
    model_run(s, p, e.ct, e.st);
    e.hand_en  = hen;
    e.hand_ct0 = h0;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [SW-1:0] s, input logic [PT-1:0] p);
    @(negedge clk);
    state_in  = s;
    pt_in     = p;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; returns latency and number of busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 2000) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    chk("done_within_bound", SW'(done), SW'(1));
    lat = cyc - start_cyc;
  endtask

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_with_expectation", SW'(0), SW'(1));
      end else begin
        e = sb.pop_front();
        chk("ct_out", SW'(ct_out), SW'(e.ct));
        chk("state_out", state_out, e.st);
        if (e.hand_en) chk("ct_bit0_hand", SW'(ct_out[0]), SW'(e.hand_ct0));
      end
    end
  end

  initial begin
    int            lat, bc, dcount;
    logic [SW-1:0] s;
    logic [PT-1:0] p;
    rst      = 1'b1;
    start    = 1'b0;
    state_in = '0;
    pt_in    = '0;
`ifdef DECRYPT_EN
    dec      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_busy", SW'(busy), SW'(0));
    chk("reset_done", SW'(done), SW'(0));
    chk("reset_ct", SW'(ct_out), SW'(0));
    chk("reset_state", state_out, SW'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All-zero state and block: first keystream bit is 0.
    push_exp('0, '0, 1'b1, 1'b0);
    issue('0, '0);
    wait_done(lat, bc);
    chk("latency", SW'(lat), SW'(LAT));
    chk("busy_cycles", SW'(bc), SW'(LAT - 1));
    chk("busy_low_at_done", SW'(busy), SW'(0));

    // Only S12 set: ks = 1 on the first step, so ct[0] = 1.
    s = '0; s[12] = 1'b1;
    push_exp(s, '0, 1'b1, 1'b1);
    issue(s, '0);
    wait_done(lat, bc);

    // Zero state, pt[0]=1: ks = 0, so ct[0] = 1.
    p = '0; p[0] = 1'b1;
    push_exp('0, p, 1'b1, 1'b1);
    issue('0, p);
    wait_done(lat, bc);

    // S12 and S154 set: S154 cancels S12 in ks, and S193 picks up S154
    // only after S230 has been updated, so ct[0] = 0.
    s = '0; s[12] = 1'b1; s[154] = 1'b1;
    push_exp(s, '0, 1'b1, 1'b0);
    issue(s, '0);
    wait_done(lat, bc);

    // Back-to-back blocks: each start on the cycle after done.
    for (int v = 0; v < 50; v++) begin
      s = rand_state();
      p = rand_pt();
      push_exp(s, p, 1'b0, 1'b0);
      issue(s, p);
      wait_done(lat, bc);
      if (v == 0) chk("latency_b2b", SW'(lat), SW'(LAT));
    end

    // Stray start pulses at ENC i=5, PAD j=0 and on the DONE cycle.
    s = rand_state();
    p = rand_pt();
    push_exp(s, p, 1'b0, 1'b0);
    issue(s, p);
    repeat (5) @(negedge clk);
    state_in = rand_state(); pt_in = rand_pt(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (122) @(negedge clk);
    state_in = rand_state(); pt_in = rand_pt(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk("latency_ignored_starts", SW'(lat), SW'(LAT));
    state_in = rand_state(); pt_in = rand_pt(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_done_start", SW'(busy), SW'(0));

    // Reset at PAD j=100: outputs clear at once, no done afterwards.
    issue(rand_state(), rand_pt());
    repeat (228) @(negedge clk);
    chk("busy_before_abort", SW'(busy), SW'(1));
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", SW'(busy), SW'(0));
    chk("abort_done", SW'(done), SW'(0));
    chk("abort_ct", SW'(ct_out), SW'(0));
    chk("abort_state", state_out, SW'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("no_done_after_abort", SW'(dcount), SW'(0));

    // Normal operation after the abort.
    s = rand_state();
    p = rand_pt();
    push_exp(s, p, 1'b0, 1'b0);
    issue(s, p);
    wait_done(lat, bc);

`ifdef DECRYPT_EN
    begin
      exp_t e;
      s = rand_state();
      p = rand_pt();
      model_run(s, p, e.ct, e.st);
      e.hand_en = 1'b0;
      e.hand_ct0 = 1'b0;
      sb.push_back(e);
      dec = 1'b0;
      issue(s, p);
      wait_done(lat, bc);
      // Decrypting the ciphertext must return the plaintext and same state.
      sb.push_back('{ct: p, st: e.st, hand_en: 1'b0, hand_ct0: 1'b0});
      dec = 1'b1;
      issue(s, e.ct);
      dec = 1'b0;
      wait_done(lat, bc);
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", SW'(sb.size()), SW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plaintext_process.md
Name: plaintext_process

Overview:
Encryption stage of the ACORN-128 core. It sits directly downstream of associated-data processing.
- Takes the 293-bit state that stage produces, plus one plaintext block.
- Runs one StateUpdate128 step per cycle. Emits one ciphertext bit per plaintext bit.
- Then absorbs the plaintext padding (1 followed by 255 zeros).
- Hands the final state to the finalization stage.

Parameters:
PT_BITS, 128, plaintext/ciphertext block length in bits (1..1024)
STATE_W, 293, ACORN state width; fixed, not to be overridden

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; accepted only in IDLE
state_in  in  293  state from associated-data stage; sampled with start
pt_in  in  PT_BITS  plaintext block, bit 0 processed first; sampled with start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle pulse; ct_out and state_out valid and held from then on
ct_out  out  PT_BITS  ciphertext block
state_out  out  293  state after plaintext and padding

Behaviour:
- Reset (async, any state): FSM=IDLE, counter=0, state register=0, pt/ct registers=0, busy=0, done=0.
- FSM states:
  - IDLE: on start, load state_in and pt_in, clear counter, go to ENC. Otherwise stay.
  - ENC: PT_BITS cycles, i=0..PT_BITS-1.
  - PAD: 256 cycles, j=0..255.
  - DONE: 1 cycle, done=1, then IDLE.
- Counter: 10 bits. Clears on each state entry and increments every cycle in ENC/PAD. The exit comparison is made on the terminal count (PT_BITS-1, 255), so there is no wrap-around.
- Step inputs per cycle:
  - ENC: m=pt[i], ca=1, cb=0. ct[i] <= pt[i] ^ ks, with ks computed from the pre-update state of that same cycle.
  - PAD: m=(j==0), ca=(j<128), cb=0.
- Step function (StateUpdate128):
  - Feedback updates, in order: S289^=S235^S230; S230^=S196^S193; S193^=S160^S154; S154^=S111^S107; S107^=S66^S61; S61^=S23^S0.
  - ks=S12^S154^maj(S235,S61,S193)^ch(S230,S111,S66).
  - f=S0^~S107^maj(S244,S23,S160)^(ca&S196)^(cb&ks)^m.
  - Shift: S[k]=S[k+1]; S292=f.
  - All terms after the feedback updates use the updated values.
- Latency: start accepted at cycle 0 gives done at cycle PT_BITS+257 (385 for the default PT_BITS=128).
- start asserted while not IDLE (including the DONE cycle) is ignored; no effect on the state or counter.
- ct_out and state_out are held after done until the next accepted start. They change only during ENC/PAD.
- Reset mid-operation aborts immediately and all outputs return to reset values. No partial done.
- start and rst high together: rst wins.

Optional Feature:
DECRYPT_EN. When defined:
- Adds input dec (1 bit), sampled with start.
- With dec=1, pt_in carries ciphertext. During ENC: m=pt[i]^ks and ct[i]=pt[i]^ks, so ct_out is the recovered plaintext. The padding phase is identical.
- With dec=0, behaviour is identical to the macro being undefined.
- Without the macro: no dec port, encrypt only.

Decomposition:
- Shared package acorn_pkg holds:
  - ACORN_STATE_W=293
  - PAD_BITS=256
  - CA_ONE_BITS=128
  - FSM state enum (IDLE, ENC, PAD, DONE)
  - tap index constants (0,12,23,61,66,107,111,154,160,193,196,230,235,244,289)
- One natural sub-module: acorn_step. It is the combinational single-step function, with inputs state, m, ca, cb and outputs next_state, ks. It is reusable by the other ACORN stages.
- plaintext_process keeps the FSM, counter and registers.

Test Plan:
- rst mid-PAD (counter~100) -> busy=0, done=0, ct_out=0, state_out=0 in the same cycle; no done pulse afterwards.
- state_in=0, pt_in=0, start -> ct[0]=0 (ks=0 for the zero state); done exactly 385 cycles after start; busy high for cycles 1..384; ct_out/state_out match the golden C model.
- Random state_in/pt_in, 50 vectors, start back-to-back (next start on the cycle after done) -> every ct_out/state_out matches the golden model; no lost blocks.
- start pulsed at ENC i=5, at PAD j=0 and on the DONE cycle -> ignored; results identical to an uninterrupted run.
- With DECRYPT_EN: encrypt a random block, then feed its ct_out with the same state_in and dec=1 -> ct_out equals the original pt_in, and state_out equals the encrypt-run state_out.
